// File: rtl/event_deframer.sv
// Event deframer: hunts for a header byte, reassembles 16-byte MSB-first event words, decodes fields.
// Latency: data_valid rises the cycle after the 16th byte of a frame is accepted.
// Backpressure: byte_ready drops only at the last byte while an unacknowledged event is held.
// Optional feature: define EVENT_DEFRAMER_ID_CHECK_EN to drop frames whose block id differs from cfg_block_id.
module event_deframer #(
  parameter int ID_BITS   = 6,
  parameter int DATA_BITS = 128,
  parameter int CRC_BITS  = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           byte_in,
  input  logic                 byte_valid,
  output logic                 byte_ready,
  input  logic [ID_BITS-1:0]   cfg_block_id,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic [DATA_BITS-1:0] data_out,
  output logic [ID_BITS-1:0]   block_id_out,
  output logic [95:0]          energy_out,
  output logic [19:0]          start_time_out,
  output logic                 locked,
  output logic [15:0]          frame_err_cnt
);

  localparam int         NBYTES   = DATA_BITS / 8;
  localparam logic [3:0] LAST_IDX = 4'(NBYTES - 1);

  typedef enum logic [1:0] {
    HUNT     = 2'd0,
    ASSEMBLE = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  state_t                 state_q;
  logic [3:0]             idx_q;
  // Holds the first 15 bytes of the frame; the 16th byte arrives directly from byte_in.
  logic [DATA_BITS-9:0]   asm_q;

  logic                   accept;
  logic                   hdr_ok;
  logic [DATA_BITS-1:0]   word_next;
  logic                   id_match;

  // A byte moves the machine only when both sides agree.
  assign accept = byte_valid & byte_ready;

  // Header: all-ones framing field followed by the single-event flag.
  assign hdr_ok = (byte_in[7 -: CRC_BITS] == {CRC_BITS{1'b1}}) & byte_in[7-CRC_BITS];

  // Word as it would look with the current byte appended at the LSB end.
  assign word_next = {asm_q, byte_in};

  // Stall only the final byte, and only while the held event is still unacknowledged.
  assign byte_ready = ~((idx_q == LAST_IDX) & data_valid & ~data_ready);

`ifdef EVENT_DEFRAMER_ID_CHECK_EN
  // Completed frames addressed to another block are dropped silently.
  assign id_match = (word_next[116 +: ID_BITS] == cfg_block_id);
`else
  logic cfg_block_id_unused;
  // Identifier filtering is compiled out; every completed frame is emitted.
  assign cfg_block_id_unused = ^cfg_block_id;
  assign id_match            = 1'b1;
`endif

  // Framing FSM, assembly shift register, output registers and error counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= HUNT;
      idx_q          <= 4'd0;
      asm_q          <= '0;
      data_valid     <= 1'b0;
      locked         <= 1'b0;
      frame_err_cnt  <= 16'd0;
      data_out       <= '0;
      block_id_out   <= '0;
      energy_out     <= '0;
      start_time_out <= '0;
    end else begin
      // Acknowledge drops valid; a word completing on this edge overrides below.
      if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end

      if (accept) begin
        case (state_q)
          HUNT: begin
            // Non-header bytes are simply skipped while searching for alignment.
            if (hdr_ok) begin
              asm_q   <= (DATA_BITS-8)'(byte_in);
              idx_q   <= 4'd1;
              state_q <= ASSEMBLE;
            end
          end

          ASSEMBLE, LOCKED: begin
            if ((state_q == LOCKED) && (idx_q == 4'd0) && !hdr_ok) begin
              // Lost alignment: the offending byte is consumed, not re-hunted.
              if (frame_err_cnt != 16'hFFFF) begin
                frame_err_cnt <= frame_err_cnt + 16'd1;
              end
              locked  <= 1'b0;
              state_q <= HUNT;
            end else begin
              asm_q <= word_next[DATA_BITS-9:0];
              if (idx_q == LAST_IDX) begin
                idx_q   <= 4'd0;
                state_q <= LOCKED;
                locked  <= 1'b1;
                if (id_match) begin
                  data_valid     <= 1'b1;
                  data_out       <= word_next;
                  block_id_out   <= word_next[116 +: ID_BITS];
                  energy_out     <= word_next[115:20];
                  start_time_out <= word_next[19:0];
                end
              end else begin
                idx_q <= idx_q + 4'd1;
              end
            end
          end

          default: begin
            state_q <= HUNT;
            idx_q   <= 4'd0;
            locked  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
